input_debounce_bank: RTL and testbench

// - N-channel debouncer for buttons/switches; parametrised successor of the single-channel debouncer.
// - Per channel:
//   - synchronises the raw pin and debounces it;
//   - emits one-tick press/release pulses;
//   - detects long-press hold;
//   - optionally auto-repeats while held.
// - Sits between board pins and the input/UI logic; all outputs are in the clk domain.

---
 rtl/input_debounce_bank.sv | 150 +++++++++++++++
 tb/tb_input_debounce_bank.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/input_debounce_bank.sv
// ============================================================================
// Module   : input_debounce_bank
// Purpose  : N-channel pin debouncer with press/release pulses, long-press
//            detection and optional auto-repeat (macro DEBOUNCE_AUTOREPEAT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debounce_bank #(
  parameter int           N           = 5,
  parameter int           SYNC_STAGES = 2,
  parameter int           CNT_W       = 18,
  parameter int           HOLD_CYCLES = 50_000_000,
  parameter int           RPT_CYCLES  = 10_000_000,
  parameter logic [N-1:0] INVERT      = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] ondn,
  output logic [N-1:0] onup,
  output logic [N-1:0] held,
  output logic [N-1:0] rpt
);

  localparam int              HC_W      = $clog2(HOLD_CYCLES);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    REL = 2'd0,
    PRS = 2'd1,
    HLD = 2'd2
  } state_t;

  if (SYNC_STAGES < 2 || HOLD_CYCLES < 2 || RPT_CYCLES < 2) begin : g_bad_params
    $error("input_debounce_bank: SYNC_STAGES, HOLD_CYCLES and RPT_CYCLES must be >= 2");
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_out;
    logic                   r_ondn;
    logic                   r_onup;
    logic                   r_held;
    state_t                 r_state;
    logic [HC_W-1:0]        r_hcnt;
    logic                   w_mismatch;
    logic                   w_toggle;
    logic                   w_rise;
    logic                   w_fall;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int              RC_W     = $clog2(RPT_CYCLES);
    localparam logic [RC_W-1:0] RPT_LAST = RC_W'(RPT_CYCLES - 1);
    logic [RC_W-1:0] r_rcnt;
    logic            r_rpt;
`endif

    assign w_mismatch = (r_sync[SYNC_STAGES-1] != r_out);
    assign w_toggle   = w_mismatch && (&r_cnt);
    assign w_rise     = w_toggle && !r_out;
    assign w_fall     = w_toggle &&  r_out;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync  <= '0;
        r_cnt   <= '0;
        r_out   <= 1'b0;
        r_ondn  <= 1'b0;
        r_onup  <= 1'b0;
        r_held  <= 1'b0;
        r_state <= REL;
        r_hcnt  <= '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        r_rcnt  <= '0;
        r_rpt   <= 1'b0;
`endif
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], in[i] ^ INVERT[i]};

        // Counter wraps to zero naturally on the toggling cycle.
        if (w_mismatch) r_cnt <= r_cnt + 1'b1;
        else            r_cnt <= '0;

        if (w_toggle) r_out <= ~r_out;

        r_ondn <= w_rise;
        r_onup <= w_fall;
        r_held <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        r_rpt  <= 1'b0;
`endif

        // Release takes priority and suppresses a coinciding held/rpt.
        if (w_fall) begin
          r_state <= REL;
          r_hcnt  <= '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
          r_rcnt  <= '0;
`endif
        end else begin
          case (r_state)
            REL: begin
              if (w_rise) begin
                r_state <= PRS;
                r_hcnt  <= '0;
              end
            end
            PRS: begin
              if (r_hcnt == HOLD_LAST) begin
                r_state <= HLD;
                r_held  <= 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                r_rcnt  <= '0;
`endif
              end else begin
                r_hcnt <= r_hcnt + 1'b1;
              end
            end
            HLD: begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
              if (r_rcnt == RPT_LAST) begin
                r_rpt  <= 1'b1;
                r_rcnt <= '0;
              end else begin
                r_rcnt <= r_rcnt + 1'b1;
              end
`endif
            end
            default: r_state <= REL;
          endcase
        end
      end
    end

    assign out[i]  = r_out;
    assign ondn[i] = r_ondn;
    assign onup[i] = r_onup;
    assign held[i] = r_held;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    assign rpt[i]  = r_rpt;
`else
    assign rpt[i]  = 1'b0;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_input_debounce_bank.sv
// ============================================================================
// Module   : tb_input_debounce_bank
// Purpose  : Directed self-checking bench for input_debounce_bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_debounce_bank;

  localparam int       N    = 3;
  localparam logic [2:0] IDLE = 3'b100;
`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] pin = IDLE;
  logic [N-1:0] out, ondn, onup, held, rpt;

  int vecs = 0;
  int errs = 0;

  input_debounce_bank #(
    .N(N), .SYNC_STAGES(2), .CNT_W(4), .HOLD_CYCLES(40), .RPT_CYCLES(8),
    .INVERT(3'b100)
  ) dut (
    .clk(clk), .rst(rst), .in(pin),
    .out(out), .ondn(ondn), .onup(onup), .held(held), .rpt(rpt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pin = IDLE;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) step();
      vecs++; if (out  !== 3'b000) begin errs++; $display("FAIL reset c=%0d out=%b exp=000", c, out); end
      vecs++; if (ondn !== 3'b000) begin errs++; $display("FAIL reset c=%0d ondn=%b exp=000", c, ondn); end
      vecs++; if (onup !== 3'b000) begin errs++; $display("FAIL reset c=%0d onup=%b exp=000", c, onup); end
      vecs++; if (held !== 3'b000) begin errs++; $display("FAIL reset c=%0d held=%b exp=000", c, held); end
      vecs++; if (rpt  !== 3'b000) begin errs++; $display("FAIL reset c=%0d rpt=%b exp=000", c, rpt); end
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] e_out, e_dn;
    do_reset();
    pin = 3'b101;
    for (int c = 1; c <= 30; c++) begin
      step();
      e_out = (c >= 18) ? 3'b001 : 3'b000;
      e_dn  = (c == 18) ? 3'b001 : 3'b000;
      vecs++; if (out  !== e_out)  begin errs++; $display("FAIL clean_press c=%0d out=%b exp=%b", c, out, e_out); end
      vecs++; if (ondn !== e_dn)   begin errs++; $display("FAIL clean_press c=%0d ondn=%b exp=%b", c, ondn, e_dn); end
      vecs++; if (onup !== 3'b000) begin errs++; $display("FAIL clean_press c=%0d onup=%b exp=000", c, onup); end
      vecs++; if (held !== 3'b000) begin errs++; $display("FAIL clean_press c=%0d held=%b exp=000", c, held); end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int c = 0; c < 80; c++) begin
      pin = (c < 60 && ((c / 10) % 2 == 0)) ? 3'b110 : IDLE;
      step();
      vecs++; if (out  !== 3'b000) begin errs++; $display("FAIL glitch c=%0d out=%b exp=000", c, out); end
      vecs++; if (ondn !== 3'b000) begin errs++; $display("FAIL glitch c=%0d ondn=%b exp=000", c, ondn); end
      vecs++; if (onup !== 3'b000) begin errs++; $display("FAIL glitch c=%0d onup=%b exp=000", c, onup); end
    end
  endtask

  task automatic test_hold_repeat();
    logic [2:0] e_out, e_dn, e_up, e_hd, e_rp;
    do_reset();
    pin = 3'b101;
    for (int c = 1; c <= 125; c++) begin
      step();
      e_out = (c >= 18 && c < 118) ? 3'b001 : 3'b000;
      e_dn  = (c == 18)  ? 3'b001 : 3'b000;
      e_up  = (c == 118) ? 3'b001 : 3'b000;
      e_hd  = (c == 58)  ? 3'b001 : 3'b000;
      e_rp  = (AR && c > 58 && c < 118 && ((c - 58) % 8 == 0)) ? 3'b001 : 3'b000;
      vecs++; if (out  !== e_out) begin errs++; $display("FAIL hold c=%0d out=%b exp=%b", c, out, e_out); end
      vecs++; if (ondn !== e_dn)  begin errs++; $display("FAIL hold c=%0d ondn=%b exp=%b", c, ondn, e_dn); end
      vecs++; if (onup !== e_up)  begin errs++; $display("FAIL hold c=%0d onup=%b exp=%b", c, onup, e_up); end
      vecs++; if (held !== e_hd)  begin errs++; $display("FAIL hold c=%0d held=%b exp=%b", c, held, e_hd); end
      vecs++; if (rpt  !== e_rp)  begin errs++; $display("FAIL hold c=%0d rpt=%b exp=%b", c, rpt, e_rp); end
      if (c == 100) pin = IDLE;
    end
  endtask

  task automatic test_release_race();
    logic [2:0] e_out, e_up;
    do_reset();
    pin = 3'b101;
    for (int c = 1; c <= 110; c++) begin
      step();
      e_out = (c >= 18 && c < 58) ? 3'b001 : 3'b000;
      e_up  = (c == 58) ? 3'b001 : 3'b000;
      vecs++; if (out  !== e_out)  begin errs++; $display("FAIL race c=%0d out=%b exp=%b", c, out, e_out); end
      vecs++; if (onup !== e_up)   begin errs++; $display("FAIL race c=%0d onup=%b exp=%b", c, onup, e_up); end
      vecs++; if (held !== 3'b000) begin errs++; $display("FAIL race c=%0d held=%b exp=000", c, held); end
      vecs++; if (rpt  !== 3'b000) begin errs++; $display("FAIL race c=%0d rpt=%b exp=000", c, rpt); end
      if (c == 40) pin = IDLE;
    end
  endtask

  task automatic test_concurrent();
    logic [2:0] e_out, e_dn;
    do_reset();
    pin = 3'b011;
    for (int c = 1; c <= 25; c++) begin
      step();
      e_out = (c >= 18) ? 3'b111 : 3'b000;
      e_dn  = (c == 18) ? 3'b111 : 3'b000;
      vecs++; if (out  !== e_out)  begin errs++; $display("FAIL concurrent c=%0d out=%b exp=%b", c, out, e_out); end
      vecs++; if (ondn !== e_dn)   begin errs++; $display("FAIL concurrent c=%0d ondn=%b exp=%b", c, ondn, e_dn); end
      vecs++; if (onup !== 3'b000) begin errs++; $display("FAIL concurrent c=%0d onup=%b exp=000", c, onup); end
    end
  endtask

  task automatic test_reset_mid_press();
    logic [2:0] e_out, e_dn;
    do_reset();
    pin = 3'b101;
    repeat (25) step();
    vecs++; if (out !== 3'b001) begin errs++; $display("FAIL midreset pre out=%b exp=001", out); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++; if (out  !== 3'b000) begin errs++; $display("FAIL midreset rst out=%b exp=000", out); end
    vecs++; if (ondn !== 3'b000) begin errs++; $display("FAIL midreset rst ondn=%b exp=000", ondn); end
    vecs++; if (onup !== 3'b000) begin errs++; $display("FAIL midreset rst onup=%b exp=000", onup); end
    vecs++; if (held !== 3'b000) begin errs++; $display("FAIL midreset rst held=%b exp=000", held); end
    vecs++; if (rpt  !== 3'b000) begin errs++; $display("FAIL midreset rst rpt=%b exp=000", rpt); end
    for (int c = 1; c <= 25; c++) begin
      step();
      e_out = (c >= 18) ? 3'b001 : 3'b000;
      e_dn  = (c == 18) ? 3'b001 : 3'b000;
      vecs++; if (out  !== e_out)  begin errs++; $display("FAIL midreset c=%0d out=%b exp=%b", c, out, e_out); end
      vecs++; if (ondn !== e_dn)   begin errs++; $display("FAIL midreset c=%0d ondn=%b exp=%b", c, ondn, e_dn); end
      vecs++; if (onup !== 3'b000) begin errs++; $display("FAIL midreset c=%0d onup=%b exp=000", c, onup); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_hold_repeat();
    test_release_race();
    test_concurrent();
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
